// File: rtl/display_scanner.sv
// Four-digit multiplexed seven-segment scanner with a one-entry
// pending buffer that commits at frame end, plus leading-zero blanking.
module display_scanner #(
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0] G_LAST = TW'(GUARD_CYCLES - 1);

    typedef enum logic {
        S_GUARD,
        S_ACTIVE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    index_q, index_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [15:0]   act_value_q, act_value_d;
    logic [3:0]    act_dp_q, act_dp_d;
    logic          act_blank_q, act_blank_d;

    logic [15:0]   pend_value_q, pend_value_d;
    logic [3:0]    pend_dp_q, pend_dp_d;
    logic          pend_blank_q, pend_blank_d;
    logic          pend_valid_q, pend_valid_d;

    logic [3:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;

    logic          frame_end;
    logic          accept;
    logic [3:0]    nib;
    logic          blank;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            4'hF: s = 7'h47;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign load_ready = ~pend_valid_q;
    assign accept     = load_valid & load_ready;
    assign an         = an_q;
    assign seg        = seg_q;

    // Slot sequencing: GUARD then ACTIVE, index advances on GUARD entry
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        frame_end = 1'b0;
        timer_d   = (timer_q == T_LAST) ? '0 : timer_q + TW'(1);
        unique case (state_q)
            S_GUARD: begin
                if (timer_q == G_LAST) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (timer_q == T_LAST) begin
                    state_d   = S_GUARD;
                    index_d   = index_q + 2'd1;
                    frame_end = (index_q == 2'd3);
                end
            end
            default: state_d = S_GUARD;
        endcase
    end

    always_comb begin
        act_value_d  = act_value_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        pend_value_d = pend_value_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_valid_d = pend_valid_q;
        if (frame_end && pend_valid_q) begin
            act_value_d  = pend_value_q;
            act_dp_d     = pend_dp_q;
            act_blank_d  = pend_blank_q;
            pend_valid_d = 1'b0;
        end
        if (accept) begin
            pend_value_d = value;
            pend_dp_d    = dp;
            pend_blank_d = blank_lz;
            pend_valid_d = 1'b1;
        end
    end

    // A digit is blank when it and every more significant nibble is zero
    always_comb begin
        nib   = act_value_q[{index_q, 2'b00} +: 4];
        blank = 1'b0;
        unique case (index_q)
            2'd3: blank = (act_value_q[15:12] == 4'h0);
            2'd2: blank = (act_value_q[15:8] == 8'h00);
            2'd1: blank = (act_value_q[15:4] == 12'h000);
            default: blank = 1'b0;
        endcase
        blank = blank & act_blank_q;
    end

    always_comb begin
        an_d  = 4'b0000;
        seg_d = 8'h00;
        if (state_q == S_ACTIVE && !blank) begin
            an_d  = 4'b0001 << index_q;
            seg_d = {act_dp_q[index_q], hex7(nib)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_GUARD;
            index_q      <= 2'd0;
            timer_q      <= '0;
            act_value_q  <= 16'h0000;
            act_dp_q     <= 4'h0;
            act_blank_q  <= 1'b0;
            pend_value_q <= 16'h0000;
            pend_dp_q    <= 4'h0;
            pend_blank_q <= 1'b0;
            pend_valid_q <= 1'b0;
            an_q         <= 4'b0000;
            seg_q        <= 8'h00;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            timer_q      <= timer_d;
            act_value_q  <= act_value_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            pend_value_q <= pend_value_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_valid_q <= pend_valid_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with REFRESH_DIV=8, GUARD_CYCLES=2.
module tb_display_scanner;

    localparam int RD = 8;
    localparam int GC = 2;
    localparam int FR = 4 * RD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] value = 16'h0000;
    logic [3:0]  dp = 4'h0;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [7:0]  seg;

    int tests = 0;
    int fails = 0;
    int k = 0;

    typedef struct {
        logic [15:0]      value;
        logic [3:0]       dp;
        logic             bl;
        logic [3:0]       lit;
        logic [3:0][7:0]  seg;
    } vec_t;

    vec_t tbl [9];
    int   order [6];

    display_scanner #(.REFRESH_DIV(RD), .GUARD_CYCLES(GC)) dut (
        .clk(clk),
        .rst(rst),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .value(value),
        .dp(dp),
        .blank_lz(blank_lz),
        .an(an),
        .seg(seg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) k <= rst ? 0 : k + 1;

    // One-hot anodes, and dark anodes in every guard slot position
    always @(negedge clk) begin
        if (!rst && k >= 1) begin
            tests++;
            if ($countones(an) > 1 || (((k - 1) % RD) < GC && an != 4'b0000)) begin
                fails++;
                $display("FAIL an_onehot_guard k=%0d an=%b", k, an);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s k=%0d got %h want %h", name, k, act, exp);
        end
    endtask

    task automatic check_cycle(input vec_t e);
        int p;
        int d;
        logic [3:0] ea;
        logic [7:0] es;
        ea = 4'b0000;
        es = 8'h00;
        if (k >= 1) begin
            p = (k - 1) % RD;
            d = ((k - 1) / RD) % 4;
            if (p >= GC && e.lit[d]) begin
                ea = 4'b0001 << d;
                es = e.seg[d];
            end
        end
        chk("an", 32'(an), 32'(ea));
        chk("seg", 32'(seg), 32'(es));
    endtask

    task automatic step_check(input vec_t e);
        @(posedge clk);
        @(negedge clk);
        check_cycle(e);
    endtask

    task automatic check_cycles(input vec_t e, input int n);
        for (int i = 0; i < n; i++) step_check(e);
    endtask

    task automatic run_to_frame_end(input vec_t e);
        for (int i = 0; i < FR + 8; i++) begin
            step_check(e);
            if (k % FR == 0) return;
        end
        chk("frame_end_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_pos(input vec_t e, input int target);
        for (int i = 0; i < FR + 8; i++) begin
            if ((k - 1) % FR == target) return;
            step_check(e);
        end
        chk("wait_pos_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_load(input vec_t cur, input vec_t n);
        for (int i = 0; i < FR + 8; i++) begin
            if (load_ready) break;
            step_check(cur);
        end
        chk("ready_before_load", 32'(load_ready), 32'd1);
        value      = n.value;
        dp         = n.dp;
        blank_lz   = n.bl;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        chk("ready_drop", 32'(load_ready), 32'd0);
        @(negedge clk);
        check_cycle(cur);
    endtask

    initial begin
        tbl[0] = '{value: 16'h0000, dp: 4'b0000, bl: 1'b0, lit: 4'b1111,
                   seg: {8'h7E, 8'h7E, 8'h7E, 8'h7E}};
        tbl[1] = '{value: 16'h12AF, dp: 4'b0100, bl: 1'b0, lit: 4'b1111,
                   seg: {8'h30, 8'hED, 8'h77, 8'h47}};
        tbl[2] = '{value: 16'h0005, dp: 4'b0000, bl: 1'b1, lit: 4'b0001,
                   seg: {8'h00, 8'h00, 8'h00, 8'h5B}};
        tbl[3] = '{value: 16'h0000, dp: 4'b0000, bl: 1'b1, lit: 4'b0001,
                   seg: {8'h00, 8'h00, 8'h00, 8'h7E}};
        tbl[4] = '{value: 16'h0030, dp: 4'b1001, bl: 1'b1, lit: 4'b0011,
                   seg: {8'h00, 8'h00, 8'h79, 8'hFE}};
        tbl[5] = '{value: 16'h8000, dp: 4'b0000, bl: 1'b1, lit: 4'b1111,
                   seg: {8'h7F, 8'h7E, 8'h7E, 8'h7E}};
        tbl[6] = '{value: 16'h0B06, dp: 4'b0010, bl: 1'b1, lit: 4'b0111,
                   seg: {8'h00, 8'h1F, 8'hFE, 8'h5F}};
        tbl[7] = '{value: 16'hC4D9, dp: 4'b1000, bl: 1'b0, lit: 4'b1111,
                   seg: {8'hCE, 8'h33, 8'h3D, 8'h7B}};
        tbl[8] = '{value: 16'h0E70, dp: 4'b0000, bl: 1'b0, lit: 4'b1111,
                   seg: {8'h7E, 8'h4F, 8'h70, 8'h7E}};
        order = '{2, 4, 5, 6, 7, 8};

        // Reset state, then two idle frames of zeros
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_an", 32'(an), 32'd0);
        chk("rst_seg", 32'(seg), 32'd0);
        chk("rst_ready", 32'(load_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_cycles(tbl[0], 2 * FR);

        // Load mid-digit-1 ACTIVE; old value held until frame end
        wait_pos(tbl[0], RD + 4);
        do_load(tbl[0], tbl[1]);
        run_to_frame_end(tbl[0]);
        check_cycles(tbl[1], FR);

        begin
            int prev;
            prev = 1;
            for (int i = 0; i < 6; i++) begin
                do_load(tbl[prev], tbl[order[i]]);
                run_to_frame_end(tbl[prev]);
                check_cycles(tbl[order[i]], FR);
                prev = order[i];
            end
        end

        // load_valid held through the commit: taken the cycle after
        do_load(tbl[8], tbl[3]);
        value      = tbl[2].value;
        dp         = tbl[2].dp;
        blank_lz   = tbl[2].bl;
        load_valid = 1'b1;
        run_to_frame_end(tbl[8]);
        chk("ready_after_commit", 32'(load_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("accept_after_commit", 32'(load_ready), 32'd0);
        load_valid = 1'b0;
        @(negedge clk);
        check_cycle(tbl[3]);
        check_cycles(tbl[3], FR - 1);
        check_cycles(tbl[2], FR);

        // Reset during digit 2 ACTIVE drops the pending value
        do_load(tbl[2], tbl[1]);
        wait_pos(tbl[2], 2 * RD + 4);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_an", 32'(an), 32'd0);
        chk("midrst_seg", 32'(seg), 32'd0);
        chk("midrst_ready", 32'(load_ready), 32'd1);
        rst = 1'b0;
        check_cycles(tbl[0], 2 * FR);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000: clock cycles each digit is driven per scan slot (legal range 2 to 2^20).
REQ-002 SHALL have parameter GUARD_CYCLES, default 16: cycles with all anodes off between slots (legal range 1 to REFRESH_DIV-1).
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port load_valid, input, 1: a new display value is offered.
REQ-006 SHALL have port load_ready, output, 1: high when the pending buffer can accept a value.
REQ-007 SHALL have port value, input, 16: four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-008 SHALL have port dp, input, 4: decimal-point enables, one per digit; captured with value.
REQ-009 SHALL have port blank_lz, input, 1: leading-zero blanking enable; captured with value.
REQ-010 SHALL have port an, output, 4: one-hot active-high digit enables; an[i] drives digit i.
REQ-011 SHALL have port seg, output, 8: seg[6:0] = {a,b,c,d,e,f,g}, active-high; seg[7] = decimal point.

Function
REQ-012 SHALL hold an active register (value, dp, blank_lz) that is displayed, and a one-entry pending register with a valid flag.
REQ-013 SHALL transfer a load only on a cycle with load_valid=1 and load_ready=1; load_ready SHALL equal NOT pending_valid.
REQ-014 SHALL copy pending into active, and clear pending_valid, only at frame end: the last cycle of digit 3's ACTIVE phase.
REQ-015 SHALL, on a cycle where pending commits at frame end, keep load_ready low; a new value is first accepted the following cycle.
REQ-016 SHALL implement two states: GUARD (an=0000, seg=00) for GUARD_CYCLES cycles, then ACTIVE for REFRESH_DIV-GUARD_CYCLES cycles; a slot therefore lasts exactly REFRESH_DIV cycles.
REQ-017 SHALL advance the digit index 0->1->2->3->0 (wrap) on the GUARD entry that follows each ACTIVE phase.
REQ-018 SHALL decode in ACTIVE the current nibble to seg[6:0]: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 B=1F C=4E D=3D E=4F F=47; seg[7] = dp[index].
REQ-019 SHALL, when active blank_lz=1, blank digit i (i=3..1) in its ACTIVE phase (an=0000, seg=00) if nibbles i..3 are all zero; digit 0 is never blanked.
REQ-020 SHALL register an and seg: outputs reflect the state/index of the previous cycle (one-cycle latency), with no combinational path from inputs to outputs.
REQ-021 SHALL never assert more than one an bit in any cycle, including across state transitions.
REQ-022 SHALL use a slot timer of ceil(log2(REFRESH_DIV)) bits that wraps to 0 at REFRESH_DIV-1, with no other wrap point.

Reset
REQ-023 SHALL, while rst=1: an=0000, seg=00, state=GUARD, index=0, timer=0, active value/dp/blank_lz=0, pending_valid=0, load_ready=1.
REQ-024 SHALL discard a pending-but-uncommitted value on rst asserted mid-frame, and ignore load_valid in cycles where rst=1.
REQ-025 SHALL, after rst deasserts, begin with GUARD for digit 0; first non-zero an (0001) appears GUARD_CYCLES+1 cycles after release.

Verification (REFRESH_DIV=8, GUARD_CYCLES=2)
REQ-026 Reset release, no loads -> an sequence 0001,0010,0100,1000 repeating, each on for 6 cycles after 2 off cycles; seg=7E in every ACTIVE cycle.
REQ-027 Load value=16'h12AF, dp=4'b0100, blank_lz=0 mid-digit-1 -> load_ready drops next cycle; display unchanged until frame end; next frame digits 0..3 show 47,77,ED(6D|80),30.
REQ-028 Load value=16'h0005, blank_lz=1 -> digits 3,2,1 show an=0000 in ACTIVE; digit 0 shows an=0001, seg=5B.
REQ-029 Load value=16'h0000, blank_lz=1 -> only digit 0 lit, seg=7E; load_valid held high with a second value -> second value accepted on the cycle after commit, not on the commit cycle.
REQ-030 Assert rst for 1 cycle during digit 2 ACTIVE with a pending value -> an=0000, seg=00 next cycle; pending value never displayed; load_ready=1.
REQ-031 Throughout all scenarios -> popcount(an) <= 1 every cycle and an=0000 in every GUARD cycle (assertion).
